// File: rtl/core_desc_in_fifo.sv
`default_nettype none
// ============================================================================
// Module      : core_desc_in_fifo
// Description : Descriptor input FIFO for one RISC-V core. Buffers scheduler
//               descriptors in a DEPTH-entry RAM and presents a registered
//               show-ahead head (in_desc / in_desc_valid) that the core pops
//               with a single-cycle in_desc_taken strobe. Also reports
//               occupancy, a high-water flag and a wrapping accept counter.
// Revision    : 1.0 - initial release
// ============================================================================
module core_desc_in_fifo #(
  parameter int          DEPTH        = 16,
  parameter int          DESC_WIDTH   = 64,
  parameter int          HIGH_WATER   = 12,
  parameter int          CNT_WIDTH    = $clog2(DEPTH + 1),
  // Reset value of accept_count; left at zero in normal use. A non-zero
  // value lets simulation reach the 32-bit wrap without 2^32 pushes.
  parameter logic [31:0] ACCEPT_RESET = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DESC_WIDTH-1:0] s_desc,
  input  logic                  s_desc_valid,
  output logic                  s_desc_ready,
  output logic [DESC_WIDTH-1:0] in_desc,
  output logic                  in_desc_valid,
  input  logic                  in_desc_taken,
  output logic [CNT_WIDTH-1:0]  occupancy,
  output logic                  high_water,
  output logic [31:0]           accept_count
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  // Pointers that differ only in their MSB mean the ring is full.
  localparam logic [PTR_W-1:0] FULL_XOR = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [PTR_W-1:0] HW_LEVEL = PTR_W'(HIGH_WATER);

  logic [DESC_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_next;
  logic [PTR_W-1:0]      rd_next;
  logic [PTR_W-1:0]      count_next;
  logic                  push;
  logic                  pop;
  logic                  full_next;
  logic                  bypass;
  logic [DESC_WIDTH-1:0] head_next;

  // Next-state pointers, occupancy and the value the head register will hold.
  always_comb begin
    // Ready and valid are registered, so a pop at full cannot admit a push in
    // the same cycle and a stale taken while empty is simply ignored.
    push       = s_desc_valid && s_desc_ready;
    pop        = in_desc_taken && in_desc_valid;
    wr_next    = wr_ptr + {{ADDR_W{1'b0}}, push};
    rd_next    = rd_ptr + {{ADDR_W{1'b0}}, pop};
    count_next = wr_next - rd_next;
    full_next  = ((wr_next ^ rd_next) == FULL_XOR);
    // When the next head is the slot being written right now the RAM does not
    // hold it yet, so forward the incoming descriptor straight to the head.
    bypass     = push && (rd_next == wr_ptr);
    head_next  = bypass ? s_desc : mem[rd_next[ADDR_W-1:0]];
  end

  // Descriptor storage; contents need no reset since pointers gate validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[ADDR_W-1:0]] <= s_desc;
    end
  end

  // Pointers, head register and status flags, all registered from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      in_desc       <= '0;
      in_desc_valid <= 1'b0;
      s_desc_ready  <= 1'b1;
      occupancy     <= '0;
      high_water    <= 1'b0;
    end else begin
      wr_ptr        <= wr_next;
      rd_ptr        <= rd_next;
      // Without a pop rd_next == rd_ptr and that slot is never overwritten
      // while occupied, so the head stays stable while the core reads it.
      in_desc       <= head_next;
      in_desc_valid <= (wr_next != rd_next);
      s_desc_ready  <= !full_next;
      occupancy     <= CNT_WIDTH'(count_next);
      high_water    <= (count_next >= HW_LEVEL);
    end
  end

  // Count of accepted descriptors, wrapping naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      accept_count <= ACCEPT_RESET;
    end else if (push) begin
      accept_count <= accept_count + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_core_desc_in_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_desc_in_fifo
// Description : Directed bench for core_desc_in_fifo with a queue scoreboard
//               of accepted descriptors and a small occupancy/ready model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_desc_in_fifo;

  localparam int DEPTH      = 16;
  localparam int DESC_WIDTH = 64;
  localparam int HIGH_WATER = 12;
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1);

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [DESC_WIDTH-1:0] s_desc = '0;
  logic                  s_desc_valid = 1'b0;
  logic                  s_desc_ready;
  logic [DESC_WIDTH-1:0] in_desc;
  logic                  in_desc_valid;
  logic                  in_desc_taken = 1'b0;
  logic [CNT_WIDTH-1:0]  occupancy;
  logic                  high_water;
  logic [31:0]           accept_count;

  // Second instance whose counter starts near the wrap point.
  logic [DESC_WIDTH-1:0] b_desc = '0;
  logic                  b_valid = 1'b0;
  logic                  b_ready;
  logic [DESC_WIDTH-1:0] b_in_desc;
  logic                  b_in_valid;
  logic [CNT_WIDTH-1:0]  b_occ;
  logic                  b_hw;
  logic [31:0]           b_acc;

  always #5 clk = ~clk;

  core_desc_in_fifo #(
    .DEPTH(DEPTH), .DESC_WIDTH(DESC_WIDTH), .HIGH_WATER(HIGH_WATER), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .rst(rst),
    .s_desc(s_desc), .s_desc_valid(s_desc_valid), .s_desc_ready(s_desc_ready),
    .in_desc(in_desc), .in_desc_valid(in_desc_valid), .in_desc_taken(in_desc_taken),
    .occupancy(occupancy), .high_water(high_water), .accept_count(accept_count)
  );

  core_desc_in_fifo #(
    .DEPTH(DEPTH), .DESC_WIDTH(DESC_WIDTH), .HIGH_WATER(HIGH_WATER), .CNT_WIDTH(CNT_WIDTH),
    .ACCEPT_RESET(32'hFFFF_FFFC)
  ) dut_b (
    .clk(clk), .rst(rst),
    .s_desc(b_desc), .s_desc_valid(b_valid), .s_desc_ready(b_ready),
    .in_desc(b_in_desc), .in_desc_valid(b_in_valid), .in_desc_taken(1'b0),
    .occupancy(b_occ), .high_water(b_hw), .accept_count(b_acc)
  );

  logic [DESC_WIDTH-1:0] sb [$];
  int                    mcount = 0;
  logic [31:0]           macc   = '0;
  logic [31:0]           bacc   = 32'hFFFF_FFFC;
  int                    checks = 0;
  int                    errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every status output (and the head, when one exists) to the model.
  task automatic check_state(input string t);
    check({t, " valid"}, 64'(in_desc_valid), 64'(mcount > 0));
    check({t, " occupancy"}, 64'(occupancy), 64'(mcount));
    check({t, " high_water"}, 64'(high_water), 64'(mcount >= HIGH_WATER));
    check({t, " ready"}, 64'(s_desc_ready), 64'(mcount < DEPTH));
    check({t, " accept_count"}, 64'(accept_count), 64'(macc));
    if (mcount > 0) check({t, " head"}, in_desc, sb[0]);
  endtask

  // One clock of stimulus; the model decides acceptance from its own state.
  task automatic cycle(input logic v, input logic [63:0] d, input logic tk, input string t);
    bit mpush, mpop;
    @(negedge clk);
    rst           = 1'b0;
    s_desc_valid  = v;
    s_desc        = d;
    in_desc_taken = tk;
    mpush = v && (mcount < DEPTH);
    mpop  = tk && (mcount > 0);
    if (mpop) check({t, " pop data"}, in_desc, sb[0]);
    @(posedge clk);
    #1;
    s_desc_valid  = 1'b0;
    in_desc_taken = 1'b0;
    if (mpop) void'(sb.pop_front());
    if (mpush) begin
      sb.push_back(d);
      macc++;
    end
    mcount = mcount + int'(mpush) - int'(mpop);
    check_state(t);
  endtask

  task automatic do_reset(input string t);
    @(negedge clk);
    rst           = 1'b1;
    s_desc_valid  = 1'b0;
    in_desc_taken = 1'b0;
    b_valid       = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    mcount = 0;
    macc   = '0;
    bacc   = 32'hFFFF_FFFC;
    check_state(t);
    check({t, " b accept_count"}, 64'(b_acc), 64'(bacc));
    check({t, " b valid"}, 64'(b_in_valid), 64'd0);
  endtask

  task automatic drain(input string t);
    for (int i = 0; i < 2 * DEPTH && mcount > 0; i++) cycle(1'b0, '0, 1'b1, t);
    check({t, " empty"}, 64'(mcount), 64'd0);
  endtask

  task automatic push_b(input logic [63:0] d);
    @(negedge clk);
    rst     = 1'b0;
    b_valid = 1'b1;
    b_desc  = d;
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    bacc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    do_reset("reset");

    // Single descriptor round trip
    cycle(1'b1, 64'h1111_0000_0000_0001, 1'b0, "single push");
    cycle(1'b0, '0, 1'b1, "single pop");

    // Fill to full, hold a push at full, pop at full
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 64'hA000_0000_0000_0000 | 64'(i), 1'b0, "fill");
    cycle(1'b1, 64'hDEAD_DEAD_DEAD_DEAD, 1'b0, "full hold");
    cycle(1'b1, 64'hBEEF_BEEF_BEEF_BEEF, 1'b1, "full pop");
    drain("drain full");

    // Streaming at occupancy 5
    for (int i = 0; i < 5; i++) cycle(1'b1, 64'h5000_0000_0000_0000 | 64'(i), 1'b0, "prefill");
    for (int i = 0; i < 100; i++) cycle(1'b1, {$urandom, $urandom}, 1'b1, "stream");
    drain("drain stream");

    // Taken while empty is ignored
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, "empty taken");
    cycle(1'b1, 64'h4444_0000_0000_0004, 1'b1, "push with stale taken");
    drain("drain empty test");

    // Reset mid-fill discards contents
    for (int i = 0; i < 10; i++) cycle(1'b1, 64'h7000_0000_0000_0000 | 64'(i), 1'b0, "fill10");
    do_reset("mid reset");
    cycle(1'b1, 64'h5555_0000_0000_0005, 1'b0, "post reset push");
    drain("drain post reset");

    // accept_count wrap on the preloaded instance
    push_b(64'h1);
    push_b(64'h2);
    check("b acc FFFFFFFE", 64'(b_acc), 64'(bacc));
    check("b acc literal FFFFFFFE", 64'(b_acc), 64'h0000_0000_FFFF_FFFE);
    push_b(64'h3);
    push_b(64'h4);
    check("b acc wrap", 64'(b_acc), 64'h0000_0000_0000_0000);
    check("b occupancy", 64'(b_occ), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
